// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
// Contents:
//   DATA_BITS      : number of data bits per serial frame
//   uart_state_e   : receiver FSM state encoding
//   parity_bit()   : expected parity bit for a data byte (even or odd sense)
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Parity bit a transmitter appends: XOR of the data, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2 -- two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  : destination-domain clock
//   nrst : asynchronous active-low reset (both flops load RST_VAL)
//   d    : asynchronous input
//   q    : synchronized output
// Parameter RST_VAL selects the reset level so the same block suits idle-high
// serial lines and FIFO pointer bits alike.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two capture stages; the first may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 / 8E1 / 8O1 UART receiver that writes bytes into a FIFO.
// Ports:
//   wr_clk     : single clock, the FIFO write-domain clock
//   wr_nrst    : asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   full       : FIFO write-side full flag, looked at only at mid-stop
//   wr_en      : one-cycle FIFO write strobe
//   wr_data    : received byte, held between strobes
//   frame_err  : one-cycle pulse when the stop bit reads low
//   parity_err : one-cycle pulse when the parity bit mismatches
//   overrun    : one-cycle pulse when a good byte is dropped because full=1
// Bits are sampled at their mid-point by a down-counter loaded at the start
// edge with half a bit time. The FSM returns to IDLE at mid-stop so the next
// start edge, half a bit later, is caught for back-to-back frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 wr_clk,
  input  logic                 wr_nrst,
  input  logic                 rx,
  input  logic                 full,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ODD_SEL  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic          PAR_ON   = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  logic                 rx_s;
  logic                 rx_d_r;
  uart_state_e          state_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r;
  logic                 wr_en_r;
  logic [DATA_BITS-1:0] wr_data_r;
  logic                 frame_err_r;
  logic                 parity_err_r;
  logic                 overrun_r;
  logic                 tick_s;
  logic                 start_edge_s;

  // Line synchronizer resets high so a reset never looks like a start edge.
  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk  (wr_clk),
    .nrst (wr_nrst),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick_s       = (cnt_r == {CW{1'b0}});
  assign start_edge_s = rx_d_r & ~rx_s;

  // Previous synchronized line level, used to spot the 1->0 start edge.
  always_ff @(posedge wr_clk or negedge wr_nrst) begin
    if (!wr_nrst) begin
      rx_d_r <= 1'b1;
    end else begin
      rx_d_r <= rx_s;
    end
  end

  // Receiver FSM: bit timing, data shifting, error detection and output pulses.
  always_ff @(posedge wr_clk or negedge wr_nrst) begin
    if (!wr_nrst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      bit_idx_r    <= {BW{1'b0}};
      shift_r      <= {DATA_BITS{1'b0}};
      par_err_r    <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_data_r    <= {DATA_BITS{1'b0}};
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      wr_en_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            cnt_r     <= HALF_CNT;
            par_err_r <= 1'b0;
            state_r   <= ST_START;
          end else begin
            cnt_r <= {CW{1'b0}};
          end
        end
        ST_START: begin
          if (!tick_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else if (rx_s) begin
            // Line went back high before mid-start: treat as a glitch.
            state_r <= ST_IDLE;
          end else begin
            cnt_r     <= BIT_CNT;
            bit_idx_r <= {BW{1'b0}};
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!tick_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            // LSB arrives first, so shift in from the top.
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            cnt_r   <= BIT_CNT;
            if (bit_idx_r == LAST_BIT) begin
              state_r <= PAR_ON ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (!tick_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            par_err_r <= par_err_r | (rx_s != parity_bit(shift_r, ODD_SEL));
            cnt_r     <= BIT_CNT;
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!tick_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else if (!rx_s) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_BREAK;
          end else if (par_err_r) begin
            parity_err_r <= 1'b1;
            state_r      <= ST_IDLE;
          end else if (full) begin
            overrun_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            wr_en_r   <= 1'b1;
            wr_data_r <= shift_r;
            state_r   <= ST_IDLE;
          end
        end
        ST_BREAK: begin
          // A held-low line must rise before any new frame can start.
          if (rx_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_data    = wr_data_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning wr_clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 enables a parity bit between the last data bit and the stop bit.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 1 selects odd parity and 0 selects even; ignored when PARITY_EN=0.
REQ-004 SHALL have port wr_clk, input, 1 bit: the single clock, which is the FIFO write-domain clock.
REQ-005 SHALL have port wr_nrst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port full, input, 1 bit: FIFO write-side full flag.
REQ-008 SHALL have port wr_en, output, 1 bit: one-cycle FIFO write strobe.
REQ-009 SHALL have port wr_data, output, 8 bits: received byte, valid while wr_en=1.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because full=1.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: a rx_s 1->0 transition loads the bit counter with CLKS_PER_BIT/2-1 (integer division) and moves to START.
REQ-016 START: at counter expiry (start-bit mid-point), rx_s=1 -> IDLE (glitch rejected, no pulse); rx_s=0 -> DATA with counter reloaded to CLKS_PER_BIT-1.
REQ-017 DATA: sample rx_s at each counter expiry, 8 bits, LSB first, into a shift register; after bit 7 go to PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: sample one bit; mismatch against XOR(data)^PARITY_ODD sets a sticky internal error flag; go to STOP.
REQ-019 STOP: at mid-stop sample, rx_s=0 -> pulse frame_err, no write, go to BREAK; rx_s=1 with parity error -> pulse parity_err, no write, go to IDLE.
REQ-020 STOP with a good byte: full=0 -> pulse wr_en with wr_data=byte; full=1 -> pulse overrun, no write; either way go to IDLE.
REQ-021 All pulses SHALL assert in the cycle after the mid-stop sample edge; latency is 2 sync cycles plus the sample edge plus 1 register stage.
REQ-022 Return to IDLE SHALL occur at mid-stop, so a start edge half a bit later is accepted (back-to-back frames).
REQ-023 BREAK: wait for rx_s=1, then go to IDLE; a held-low line yields exactly one frame_err.
REQ-024 wr_en and overrun SHALL be mutually exclusive; at most one of wr_en, overrun, frame_err, parity_err asserts per frame.
REQ-025 wr_data SHALL hold its last value between strobes.
REQ-026 full is sampled only in the mid-stop cycle; a full change during the frame has no effect.

Reset
REQ-027 wr_nrst low SHALL immediately force state=IDLE, counter=0, shift register=0, wr_data=0x00, all pulse outputs=0, and both synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abandon the frame without a write; after release, reception resumes only on a fresh falling edge.

Structure
REQ-029 SHALL place the state enum and the DATA_BITS=8 constant in the shared package uart_pkg.
REQ-030 SHALL use one sub-module, sync2 (a 2-flop synchronizer with reset value parameter RST_VAL), which is reusable by the FIFO pointer synchronizers.
REQ-031 The counter width SHALL be $clog2(CLKS_PER_BIT).

Verification (CLKS_PER_BIT=16, PARITY_EN=0 unless stated)
REQ-032 Send 0xA5 with full=0 -> a single wr_en pulse with wr_data=0xA5 and no error pulses.
REQ-033 Send 0x3C then 0xC3 back-to-back with stop=1 bit -> two wr_en pulses carrying 0x3C then 0xC3.
REQ-034 Send a 4-cycle low glitch on idle rx -> no outputs, state returns to IDLE.
REQ-035 Send 0x55 with stop bit 0, then hold rx low for 40 bit times -> exactly one frame_err pulse, no wr_en, then a later 0x01 is received correctly.
REQ-036 With PARITY_EN=1 and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulse with no wr_en; with parity bit 1 -> wr_en with 0x07.
REQ-037 Hold full=1 and send 0xFF -> overrun pulse with no wr_en; assert wr_nrst mid-DATA of the next frame -> no output pulses, all outputs 0.
